// File: rtl/lpf_trk_mc.sv
// Time-multiplexed carrier/code tracking loop filter. One saturating shift-gain
// datapath walks IDLE->RD->CALC->WB per sample; per-channel state sits in lane instances.

module lpf_trk_mc_ch #(
  parameter int AW = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_dll,
  input  logic [AW-1:0] i_a1,
  input  logic [AW-1:0] i_a2,
  output logic [AW-1:0] o_dll,
  output logic [AW-1:0] o_a1,
  output logic [AW-1:0] o_a2
);
  // Clear beats write-back so a clear racing an in-flight update leaves zero state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dll <= '0;
      o_a1  <= '0;
      o_a2  <= '0;
    end else if (i_clr) begin
      o_dll <= '0;
      o_a1  <= '0;
      o_a2  <= '0;
    end else if (i_we) begin
      o_dll <= i_dll;
      o_a1  <= i_a1;
      o_a2  <= i_a2;
    end
  end
endmodule

module lpf_trk_mc #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int AW  = 64,
  parameter int FW  = 32,
  parameter int CW  = $clog2(NCH)
) (
  input  logic          rx_clk,
  input  logic          rx_rst_n,
  input  logic          rx_disc_valid,
  output logic          rx_disc_ready,
  input  logic [CW-1:0] rx_disc_ch,
  input  logic [DW-1:0] rx_pll_disc,
  input  logic [DW-1:0] rx_dll_disc,
  input  logic          rx_ch_clr,
  input  logic [CW-1:0] rx_clr_ch,
  input  logic          cfg_pll_order,
  input  logic [5:0]    cfg_pll_k0,
  input  logic [5:0]    cfg_pll_k1,
  input  logic [5:0]    cfg_pll_k2,
  input  logic [5:0]    cfg_dll_kp,
  input  logic [5:0]    cfg_dll_ki,
  output logic          tx_valid,
  output logic [CW-1:0] tx_ch,
  output logic [FW-1:0] tx_car_fcw,
  output logic [FW-1:0] tx_prn_fcw,
  output logic          tx_sat,
  output logic          rx_drop
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_CALC, S_WB} state_t;

  // Returns {clipped, sum}.
  function automatic logic [AW:0] sadd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {a[AW-1], a} + {b[AW-1], b};
    if (s[AW] != s[AW-1]) return {1'b1, s[AW], {(AW-1){~s[AW]}}};
    return {1'b0, s[AW-1:0]};
  endfunction

  function automatic logic [AW-1:0] sra(input logic [AW-1:0] x, input logic [5:0] k);
    if (int'(k) >= AW) return {AW{x[AW-1]}};
    return AW'($signed(x) >>> k);
  endfunction

  state_t r_st, w_st_nxt;
  logic [CW-1:0] r_ch;
  logic [AW-1:0] r_ep, r_ed;
  logic [AW-1:0] r_dll, r_a1, r_a2;
  logic [AW-1:0] r_nd, r_n1, r_n2, r_op, r_od;
  logic          r_sat, r_kill;
  logic          w_acc, w_clr_hit, w_we, w_sat;
  logic [AW:0]   w_sd, w_od, w_s2, w_t1, w_s1, w_op;
  logic [NCH-1:0][AW-1:0] w_dll, w_a1, w_a2;

  assign rx_disc_ready = (r_st == S_IDLE);
  assign rx_drop       = rx_disc_valid & ~rx_disc_ready;
  assign w_acc         = rx_disc_valid & rx_disc_ready;
  assign w_clr_hit     = rx_ch_clr && (rx_clr_ch == r_ch) && (r_st != S_IDLE);
  assign w_we          = (r_st == S_WB) && !r_kill && !w_clr_hit;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    lpf_trk_mc_ch #(.AW(AW)) u_ch (
      .i_clk  (rx_clk),
      .i_rst_n(rx_rst_n),
      .i_clr  (rx_ch_clr && (rx_clr_ch == CW'(g))),
      .i_we   (w_we && (r_ch == CW'(g))),
      .i_dll  (r_nd),
      .i_a1   (r_n1),
      .i_a2   (r_n2),
      .o_dll  (w_dll[g]),
      .o_a1   (w_a1[g]),
      .o_a2   (w_a2[g])
    );
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) r_st <= S_IDLE;
    else           r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      S_IDLE: if (w_acc) w_st_nxt = S_RD;
      S_RD:   w_st_nxt = S_CALC;
      S_CALC: w_st_nxt = S_WB;
      S_WB:   w_st_nxt = S_IDLE;
      default: w_st_nxt = S_IDLE;
    endcase
  end

  // Single-cycle CALC; the 3rd-order path sums a1 + a2' before the k1 term.
  always_comb begin
    w_sd = sadd(r_dll, sra(r_ed, cfg_dll_ki));
    w_od = sadd(w_sd[AW-1:0], sra(r_ed, cfg_dll_kp));
    if (cfg_pll_order) begin
      w_s2 = sadd(r_a2, sra(r_ep, cfg_pll_k2));
      w_t1 = sadd(r_a1, w_s2[AW-1:0]);
    end else begin
      w_s2 = {1'b0, r_a2};
      w_t1 = {1'b0, r_a1};
    end
    w_s1  = sadd(w_t1[AW-1:0], sra(r_ep, cfg_pll_k1));
    w_op  = sadd(w_s1[AW-1:0], sra(r_ep, cfg_pll_k0));
    w_sat = w_sd[AW] | w_od[AW] | w_s2[AW] | w_t1[AW] | w_s1[AW] | w_op[AW];
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_ch <= '0; r_ep <= '0; r_ed <= '0; r_kill <= 1'b0;
      r_dll <= '0; r_a1 <= '0; r_a2 <= '0;
      r_nd <= '0; r_n1 <= '0; r_n2 <= '0; r_op <= '0; r_od <= '0; r_sat <= 1'b0;
    end else begin
      if (w_acc) begin
        r_ch   <= rx_disc_ch;
        r_ep   <= {rx_pll_disc, {(AW-DW){1'b0}}};
        r_ed   <= {rx_dll_disc, {(AW-DW){1'b0}}};
        r_kill <= 1'b0;
      end else if (w_clr_hit) begin
        r_kill <= 1'b1;
      end
      if (r_st == S_RD) begin
        r_dll <= w_dll[r_ch];
        r_a1  <= w_a1[r_ch];
        r_a2  <= w_a2[r_ch];
      end
      if (r_st == S_CALC) begin
        r_nd  <= w_sd[AW-1:0];
        r_n1  <= w_s1[AW-1:0];
        r_n2  <= w_s2[AW-1:0];
        r_od  <= w_od[AW-1:0];
        r_op  <= w_op[AW-1:0];
        r_sat <= w_sat;
      end
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      tx_valid <= 1'b0; tx_ch <= '0; tx_car_fcw <= '0; tx_prn_fcw <= '0; tx_sat <= 1'b0;
    end else begin
      tx_valid <= w_we;
      if (w_we) begin
        tx_ch      <= r_ch;
        tx_car_fcw <= r_op[AW-1:AW-FW];
        tx_prn_fcw <= r_od[AW-1:AW-FW];
        tx_sat     <= r_sat;
      end
    end
  end
endmodule

// File: tb/tb_lpf_trk_mc.sv
// Randomized scoreboard bench for lpf_trk_mc against a plain-arithmetic longint model.
module tb_lpf_trk_mc;
  localparam int NCH = 4;

  logic        rx_clk = 1'b0, rx_rst_n = 1'b0;
  logic        rx_disc_valid = 1'b0, rx_ch_clr = 1'b0;
  logic [1:0]  rx_disc_ch = '0, rx_clr_ch = '0;
  logic [31:0] rx_pll_disc = '0, rx_dll_disc = '0;
  logic        cfg_pll_order = 1'b0;
  logic [5:0]  cfg_pll_k0 = '0, cfg_pll_k1 = '0, cfg_pll_k2 = '0, cfg_dll_kp = '0, cfg_dll_ki = '0;
  logic        rx_disc_ready, tx_valid, tx_sat, rx_drop;
  logic [1:0]  tx_ch;
  logic [31:0] tx_car_fcw, tx_prn_fcw;

  lpf_trk_mc #(.NCH(4), .DW(32), .AW(64), .FW(32)) dut (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_disc_valid(rx_disc_valid),
    .rx_disc_ready(rx_disc_ready), .rx_disc_ch(rx_disc_ch), .rx_pll_disc(rx_pll_disc),
    .rx_dll_disc(rx_dll_disc), .rx_ch_clr(rx_ch_clr), .rx_clr_ch(rx_clr_ch),
    .cfg_pll_order(cfg_pll_order), .cfg_pll_k0(cfg_pll_k0), .cfg_pll_k1(cfg_pll_k1),
    .cfg_pll_k2(cfg_pll_k2), .cfg_dll_kp(cfg_dll_kp), .cfg_dll_ki(cfg_dll_ki),
    .tx_valid(tx_valid), .tx_ch(tx_ch), .tx_car_fcw(tx_car_fcw), .tx_prn_fcw(tx_prn_fcw),
    .tx_sat(tx_sat), .rx_drop(rx_drop)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] car;
    logic [31:0] prn;
    logic        sat;
  } exp_t;

  exp_t   q[$];
  int     checks = 0, failures = 0;
  longint m_dll[NCH], m_a1[NCH], m_a2[NCH];
  bit     m_sat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat_add(input longint a, input longint b);
    longint s;
    s = a + b;
    if (a >= 0 && b >= 0 && s < 0) begin m_sat = 1'b1; return 64'sh7FFF_FFFF_FFFF_FFFF; end
    if (a < 0 && b < 0 && s >= 0) begin m_sat = 1'b1; return 64'sh8000_0000_0000_0000; end
    return s;
  endfunction

  function automatic exp_t model(input logic [1:0] ch, input logic [31:0] pd, input logic [31:0] dd);
    longint ep, ed, od, op;
    exp_t e;
    ep = longint'(int'(pd)) <<< 32;
    ed = longint'(int'(dd)) <<< 32;
    m_sat = 1'b0;
    m_dll[ch] = sat_add(m_dll[ch], ed >>> cfg_dll_ki);
    od = sat_add(m_dll[ch], ed >>> cfg_dll_kp);
    if (cfg_pll_order) begin
      m_a2[ch] = sat_add(m_a2[ch], ep >>> cfg_pll_k2);
      m_a1[ch] = sat_add(sat_add(m_a1[ch], m_a2[ch]), ep >>> cfg_pll_k1);
    end else begin
      m_a1[ch] = sat_add(m_a1[ch], ep >>> cfg_pll_k1);
    end
    op = sat_add(m_a1[ch], ep >>> cfg_pll_k0);
    e.ch = ch; e.car = op[63:32]; e.prn = od[63:32]; e.sat = m_sat;
    return e;
  endfunction

  function automatic void mzero(input logic [1:0] ch);
    m_dll[ch] = 0; m_a1[ch] = 0; m_a2[ch] = 0;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge rx_clk) begin
    if (rx_rst_n && tx_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_tx_valid", 64'(tx_valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_ch",  64'(tx_ch), 64'(e.ch));
        chk("sb_car", 64'(tx_car_fcw), 64'(e.car));
        chk("sb_prn", 64'(tx_prn_fcw), 64'(e.prn));
        chk("sb_sat", 64'(tx_sat), 64'(e.sat));
      end
    end
  end

  // Called just after a rising edge with the DUT idle; returns just after T+4's edge.
  // clr_at: -1 none, 0 with the accept, 1..3 during RD/CALC/WB. drop_at: cycle of a stray valid.
  task automatic send(input logic [1:0] ch, input logic [31:0] pd, input logic [31:0] dd,
                      input int clr_at, input logic [1:0] clr_ch, input int drop_at);
    bit   exp_v;
    exp_t e;
    exp_v = 1'b1;
    rx_disc_valid = 1'b1; rx_disc_ch = ch; rx_pll_disc = pd; rx_dll_disc = dd;
    if (clr_at == 0) begin rx_ch_clr = 1'b1; rx_clr_ch = clr_ch; mzero(clr_ch); end
    chk("ready_idle", 64'(rx_disc_ready), 64'd1);
    e = model(ch, pd, dd);
    if (clr_at > 0) begin
      mzero(clr_ch);
      if (clr_ch == ch) exp_v = 1'b0;
    end
    if (exp_v) q.push_back(e);
    @(posedge rx_clk); #1;
    rx_disc_valid = 1'b0; rx_ch_clr = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (clr_at == c) begin rx_ch_clr = 1'b1; rx_clr_ch = clr_ch; end
      if (drop_at == c) begin
        rx_disc_valid = 1'b1; rx_disc_ch = 2'($urandom_range(0, 3));
        rx_pll_disc = $urandom; rx_dll_disc = $urandom;
      end
      #1;
      chk("ready_busy", 64'(rx_disc_ready), 64'd0);
      chk("tx_quiet", 64'(tx_valid), 64'd0);
      if (drop_at == c) chk("drop", 64'(rx_drop), 64'd1);
      @(posedge rx_clk); #1;
      rx_disc_valid = 1'b0; rx_ch_clr = 1'b0;
    end
    chk("ready_t4", 64'(rx_disc_ready), 64'd1);
    chk("tx_valid_t4", 64'(tx_valid), 64'(exp_v));
  endtask

  task automatic idle_clr(input logic [1:0] ch);
    rx_ch_clr = 1'b1; rx_clr_ch = ch; mzero(ch);
    @(posedge rx_clk); #1;
    rx_ch_clr = 1'b0;
  endtask

  task automatic set_cfg(input logic o, input logic [5:0] k0, input logic [5:0] k1,
                         input logic [5:0] k2, input logic [5:0] kp, input logic [5:0] ki);
    cfg_pll_order = o; cfg_pll_k0 = k0; cfg_pll_k1 = k1; cfg_pll_k2 = k2;
    cfg_dll_kp = kp; cfg_dll_ki = ki;
  endtask

  initial begin
    logic [31:0] exp_ramp [3];
    logic [31:0] exp_pll [3];
    exp_ramp[0] = 32'h11; exp_ramp[1] = 32'h12; exp_ramp[2] = 32'h13;
    exp_pll[0] = 32'd1; exp_pll[1] = 32'd3; exp_pll[2] = 32'd6;
    for (int i = 0; i < NCH; i++) mzero(2'(i));

    #12;
    chk("rst_ready", 64'(rx_disc_ready), 64'd1);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_car", 64'(tx_car_fcw), 64'd0);
    chk("rst_prn", 64'(tx_prn_fcw), 64'd0);
    chk("rst_sat", 64'(tx_sat), 64'd0);
    chk("rst_ch", 64'(tx_ch), 64'd0);
    chk("rst_drop", 64'(rx_drop), 64'd0);
    #5 rx_rst_n = 1'b1;
    @(posedge rx_clk); #1;

    // DLL ramp on ch0, back-to-back accepts.
    set_cfg(1'b0, 6'd0, 6'd0, 6'd0, 6'd4, 6'd8);
    for (int i = 0; i < 3; i++) begin
      send(2'd0, 32'd0, 32'h100, -1, 2'd0, 0);
      chk("ramp_prn", 64'(tx_prn_fcw), 64'(exp_ramp[i]));
      chk("ramp_ch", 64'(tx_ch), 64'd0);
    end

    // 3rd-order PLL on ch1.
    set_cfg(1'b1, 6'd63, 6'd63, 6'd0, 6'd0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      send(2'd1, 32'd1, 32'd0, -1, 2'd0, 0);
      chk("pll3_car", 64'(tx_car_fcw), 64'(exp_pll[i]));
    end

    // Interleaved ch1/ch2 with random config, strays and clears.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] ch;
      int         ca, da;
      logic [1:0] cc;
      ch = (i % 2 == 1) ? 2'd2 : 2'd1;
      set_cfg(1'($urandom_range(0, 1)), 6'($urandom_range(0, 40)), 6'($urandom_range(0, 40)),
              6'($urandom_range(0, 40)), 6'($urandom_range(0, 40)), 6'($urandom_range(0, 40)));
      da = (i % 5 == 0) ? 2 : 0;
      ca = -1; cc = 2'd0;
      if (i % 7 == 3) begin ca = $urandom_range(0, 3); cc = 2'(2 * $urandom_range(0, 1) + 0) ^ 2'd0; cc = (cc == 2'd2) ? 2'd3 : 2'd0; end
      if (i % 11 == 5) begin ca = $urandom_range(0, 3); cc = ch; end
      send(ch, $urandom, $urandom, ca, cc, da);
    end

    // Saturation, positive then negative, from zero state.
    set_cfg(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);
    idle_clr(2'd0);
    send(2'd0, 32'd0, 32'h7FFF_FFFF, -1, 2'd0, 0);
    chk("sat_pos_prn", 64'(tx_prn_fcw), 64'h7FFF_FFFF);
    chk("sat_pos_flag", 64'(tx_sat), 64'd1);
    idle_clr(2'd0);
    send(2'd0, 32'd0, 32'h8000_0000, -1, 2'd0, 0);
    chk("sat_neg_prn", 64'(tx_prn_fcw), 64'h8000_0000);
    chk("sat_neg_flag", 64'(tx_sat), 64'd1);

    // Clear races on ch3.
    set_cfg(1'b0, 6'd0, 6'd0, 6'd0, 6'd4, 6'd8);
    send(2'd3, 32'd0, 32'h100, -1, 2'd0, 0);
    send(2'd3, 32'd0, 32'h100, 3, 2'd3, 0);
    send(2'd3, 32'd0, 32'h100, -1, 2'd0, 0);
    chk("clr_wb_prn", 64'(tx_prn_fcw), 64'h11);
    send(2'd3, 32'd0, 32'h100, 0, 2'd3, 0);
    chk("clr_acc_prn", 64'(tx_prn_fcw), 64'h11);

    // Reset during CALC of a ch2 update; outputs hold the ch3 result until then.
    rx_disc_valid = 1'b1; rx_disc_ch = 2'd2; rx_pll_disc = $urandom; rx_dll_disc = $urandom;
    @(posedge rx_clk); #1;
    rx_disc_valid = 1'b0;
    @(posedge rx_clk); #1;
    rx_rst_n = 1'b0; #1;
    chk("mrst_tx_valid", 64'(tx_valid), 64'd0);
    chk("mrst_car", 64'(tx_car_fcw), 64'd0);
    chk("mrst_prn", 64'(tx_prn_fcw), 64'd0);
    chk("mrst_ch", 64'(tx_ch), 64'd0);
    chk("mrst_sat", 64'(tx_sat), 64'd0);
    chk("mrst_ready", 64'(rx_disc_ready), 64'd1);
    for (int i = 0; i < NCH; i++) mzero(2'(i));
    @(posedge rx_clk); #3;
    rx_rst_n = 1'b1;
    @(posedge rx_clk); #1;
    chk("mrst_no_strobe", 64'(tx_valid), 64'd0);
    send(2'd2, 32'd0, 32'h100, -1, 2'd0, 0);
    chk("mrst_after_prn", 64'(tx_prn_fcw), 64'h11);
    send(2'd1, 32'd3, 32'h40, -1, 2'd0, 0);

    repeat (3) @(posedge rx_clk);
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lpf_trk_mc.md
Name: lpf_trk_mc

Overview:
- Multi-channel, time-multiplexed carrier/code tracking loop filter.
- Sits between the per-channel discriminators and the carrier/code NCOs.
- One shared shift-gain datapath serves NCH channels, with per-channel state held in registers.
- Extends the single-channel fixed-gain filter with:
  - runtime-configurable gains,
  - selectable 2nd/3rd-order PLL,
  - saturating accumulators,
  - per-channel clear,
  - a valid/ready handshake.

Parameters:
- NCH, 4, number of channels (power of 2, ≥2); CW = log2(NCH).
- DW, 32, discriminator width (signed).
- AW, 64, accumulator width (signed, ≥ 2*DW).
- FW, 32, output FCW width; FCW = acc[AW-1:AW-FW].

Ports:
- rx_clk  in  1  clock.
- rx_rst_n  in  1  asynchronous active-low reset.
- rx_disc_valid  in  1  discriminator sample valid.
- rx_disc_ready  out  1  filter can accept a sample.
- rx_disc_ch  in  CW  channel index of the sample.
- rx_pll_disc  in  DW  signed carrier discriminator.
- rx_dll_disc  in  DW  signed code discriminator.
- rx_ch_clr  in  1  clear state of channel rx_clr_ch.
- rx_clr_ch  in  CW  channel to clear.
- cfg_pll_order  in  1  0 = 2nd-order PLL, 1 = 3rd-order PLL.
- cfg_pll_k0, cfg_pll_k1, cfg_pll_k2  in  6 each  PLL arithmetic right-shift gains.
- cfg_dll_kp, cfg_dll_ki  in  6 each  DLL shift gains.
- tx_valid  out  1  one-cycle result strobe.
- tx_ch  out  CW  channel of the result.
- tx_car_fcw  out  FW  carrier FCW.
- tx_prn_fcw  out  FW  code FCW.
- tx_sat  out  1  saturation occurred in this update.
- rx_drop  out  1  pulse: valid asserted while not ready; sample discarded.

Behaviour:
- Reset (async, rx_rst_n low):
  - All per-channel state zero; FSM in IDLE.
  - rx_disc_ready=1; tx_valid=0, tx_ch=0, tx_car_fcw=0, tx_prn_fcw=0, tx_sat=0, rx_drop=0.
  - Reset asserted mid-update aborts the update; nothing is written back.
- Per-channel state: dll_int, pll_a1, pll_a2, each AW bits signed.
- FSM: IDLE -> RD -> CALC -> WB -> IDLE.
  - Accept when rx_disc_valid & rx_disc_ready in IDLE (cycle T).
  - Channel index and both discriminators are captured at T.
  - rx_disc_ready=0 from T+1 to T+3, and returns to 1 at T+4.
  - RD (T+1): select channel state.
  - CALC (T+2): compute.
  - WB (T+3): write state, register outputs.
  - tx_valid=1 at T+4 for exactly one cycle. Back-to-back accepts at T, T+4, T+8, ...
  - Outputs hold their last values between strobes.
- Arithmetic:
  - Scaling: e_p = sext(rx_pll_disc) << (AW-DW); e_d likewise for rx_dll_disc.
  - `>>>k` is an arithmetic shift; shifts ≥ AW yield 0 or -1 by sign.
  - Every add is signed-saturating to AW bits. Any clip sets tx_sat for that update.
  - DLL: dll_int' = dll_int + (e_d>>>ki); out_d = dll_int' + (e_d>>>kp).
  - PLL, order 0: pll_a1' = pll_a1 + (e_p>>>k1); out_p = pll_a1' + (e_p>>>k0). pll_a2 is unchanged.
  - PLL, order 1: pll_a2' = pll_a2 + (e_p>>>k2); pll_a1' = pll_a1 + pll_a2' + (e_p>>>k1); out_p = pll_a1' + (e_p>>>k0).
  - tx_car_fcw = out_p[AW-1:AW-FW]; tx_prn_fcw = out_d[AW-1:AW-FW] (truncation).
- Config:
  - cfg_* are sampled at CALC.
  - Changing cfg_pll_order does not clear state.
- Clear:
  - rx_ch_clr zeroes all three accumulators of rx_clr_ch in the cycle asserted.
  - Clear coinciding with an accept of the same channel: clear applies first, and the update runs from zero state.
  - Clear of the in-flight channel during RD/CALC/WB: write-back is suppressed, no tx_valid, and the state ends at zero.
  - Clear of a different channel never affects the in-flight update.
- Drop: rx_disc_valid=1 while rx_disc_ready=0 raises rx_drop for that cycle. State is unchanged.

Test Plan:
- Reset mid-operation: assert rx_rst_n=0 at CALC -> no tx_valid; all outputs 0; ready=1; the next update on that channel starts from zero.
- DLL ramp: ch0, kp=4, ki=8, dll_disc=0x100, three accepts -> tx_prn_fcw = 0x11, then 0x12, then 0x13; tx_valid each at T+4; tx_ch=0.
- 3rd-order PLL: k0=63, k1=63, k2=0, order=1, pll_disc=1, three updates -> tx_car_fcw = 1, 3, 6.
- Isolation, drop and timing:
  - Interleave ch1/ch2 at a 4-cycle spacing with distinct discriminators -> per-channel results match an independent reference model.
  - Valid at T+2 -> rx_drop=1 and the sample is ignored.
- Saturation: dll_disc=0x7FFFFFFF, ki=0, kp=0 -> first update tx_prn_fcw=0x7FFFFFFF, tx_sat=1; negative mirror 0x80000000 -> 0x80000000, tx_sat=1.
- Clear races:
  - Clear ch3 during WB of ch3 -> no tx_valid; the next ch3 update with dll_disc=0x100, kp=4, ki=8 gives 0x11.
  - Clear coinciding with an accept on ch3 -> result as from zero state.
